// File: rtl/tpu_ctrl_if.sv
// Signal bundle between the matrix-multiply sequencer, its host and the systolic array.
// Strobe semantics: in_valid is a one-cycle start pulse with no ready; it is accepted only while busy is low, and is otherwise dropped.
interface tpu_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [4:0]        m;
    logic [4:0]        n;
    logic [4:0]        k;
    logic              out_valid;
    logic              busy;
    logic              a_rd_en;
    logic              b_rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              pe_clear;
    logic              pe_feed;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_addr;
    logic [2:0]        out_lane;
    logic [4:0]        pe_row;

    modport slave (
        input  in_valid, m, n, k,
        output out_valid, busy, a_rd_en, b_rd_en, a_addr, b_addr,
               pe_clear, pe_feed, out_wr_en, out_addr, out_lane, pe_row
    );

    modport master (
        output in_valid, m, n, k,
        input  out_valid, busy, a_rd_en, b_rd_en, a_addr, b_addr,
               pe_clear, pe_feed, out_wr_en, out_addr, out_lane, pe_row
    );
endinterface

// File: rtl/tpu_ctrl.sv
// Output-stationary matmul sequencer: walks C tiles (nt inner, mt outer), feeding,
// flushing and draining a TILE x TILE systolic array. All outputs are registered.
module tpu_ctrl #(
    parameter int TILE   = 4,
    parameter int ADDR_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    tpu_ctrl_if.slave  bus,
    output logic [2:0] o_dbg_state
);
    localparam int LOG_T = $clog2(TILE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state, w_nxt_state;
    logic [4:0]        r_m, r_n, r_k;
    logic [4:0]        r_mt, r_nt, w_nxt_mt, w_nxt_nt;
    logic [5:0]        r_cnt, w_nxt_cnt;
    logic [4:0]        w_mt_last, w_nt_last;
    logic [5:0]        w_m_dim, w_n_dim, w_k_dim;
    logic [ADDR_W-1:0] w_a_addr, w_b_addr, w_row, w_col0;

    logic              r_out_valid, r_busy, r_rd_en, r_pe_clear, r_pe_feed, r_out_wr_en;
    logic [ADDR_W-1:0] r_a_addr, r_b_addr, r_out_addr;
    logic [2:0]        r_out_lane;
    logic [4:0]        r_pe_row;

    assign w_mt_last = r_m >> LOG_T;
    assign w_nt_last = r_n >> LOG_T;
    assign w_m_dim   = {1'b0, r_m} + 6'd1;
    assign w_n_dim   = {1'b0, r_n} + 6'd1;
    assign w_k_dim   = {1'b0, r_k} + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mt    <= '0;
            r_nt    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_mt    <= w_nxt_mt;
            r_nt    <= w_nxt_nt;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_m <= bus.m;
            r_n <= bus.n;
            r_k <= bus.k;
        end
    end

    // r_cnt is shared: kk in FEED, flush cycle in FLUSH, drained row r in DRAIN.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mt    = r_mt;
        w_nxt_nt    = r_nt;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_nxt_state = S_CLEAR;
                    w_nxt_mt    = '0;
                    w_nxt_nt    = '0;
                    w_nxt_cnt   = '0;
                end
            end
            S_CLEAR: begin
                w_nxt_state = S_FEED;
                w_nxt_cnt   = '0;
            end
            S_FEED: begin
                if (r_cnt == {1'b0, r_k}) begin
                    w_nxt_state = S_FLUSH;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 6'd1;
                end
            end
            S_FLUSH: begin
                if (r_cnt == 6'(2 * TILE - 2)) begin
                    w_nxt_state = S_DRAIN;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 6'd1;
                end
            end
            S_DRAIN: begin
                if (r_cnt == 6'(TILE - 1)) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_CLEAR;
                    if (r_nt != w_nt_last) begin
                        w_nxt_nt = r_nt + 5'd1;
                    end else begin
                        w_nxt_nt = '0;
                        if (r_mt == w_mt_last) w_nxt_state = S_DONE;
                        else                   w_nxt_mt    = r_mt + 5'd1;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 6'd1;
                end
            end
            S_DONE:  w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Outputs are computed from the next-state view so the registered copies line up with the state.
    assign w_a_addr = ADDR_W'(w_nxt_mt) * ADDR_W'(w_k_dim) + ADDR_W'(w_nxt_cnt);
    assign w_b_addr = ADDR_W'(w_nxt_nt) * ADDR_W'(w_k_dim) + ADDR_W'(w_nxt_cnt);
    assign w_row    = ADDR_W'(w_nxt_mt) * ADDR_W'(TILE) + ADDR_W'(w_nxt_cnt);
    assign w_col0   = ADDR_W'(w_nxt_nt) * ADDR_W'(TILE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_a_addr    <= '0;
            r_b_addr    <= '0;
            r_pe_clear  <= 1'b0;
            r_pe_feed   <= 1'b0;
            r_out_wr_en <= 1'b0;
            r_out_addr  <= '0;
            r_out_lane  <= '0;
            r_pe_row    <= '0;
        end else begin
            r_out_valid <= (w_nxt_state == S_DONE);
            r_busy      <= (w_nxt_state != S_IDLE);
            r_rd_en     <= (w_nxt_state == S_FEED);
            r_a_addr    <= (w_nxt_state == S_FEED) ? w_a_addr : '0;
            r_b_addr    <= (w_nxt_state == S_FEED) ? w_b_addr : '0;
            r_pe_clear  <= (w_nxt_state == S_CLEAR);
            r_pe_feed   <= r_rd_en;
            r_out_wr_en <= (w_nxt_state == S_DRAIN) && (w_row < ADDR_W'(w_m_dim))
                           && (w_col0 < ADDR_W'(w_n_dim));
            r_out_addr  <= (w_nxt_state == S_DRAIN) ? w_row : '0;
            r_out_lane  <= (w_nxt_state == S_DRAIN) ? 3'(w_nxt_nt) : '0;
            r_pe_row    <= (w_nxt_state == S_DRAIN) ? w_nxt_cnt[4:0] : '0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.a_rd_en   = r_rd_en;
    assign bus.b_rd_en   = r_rd_en;
    assign bus.a_addr    = r_a_addr;
    assign bus.b_addr    = r_b_addr;
    assign bus.pe_clear  = r_pe_clear;
    assign bus.pe_feed   = r_pe_feed;
    assign bus.out_wr_en = r_out_wr_en;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_lane  = r_out_lane;
    assign bus.pe_row    = r_pe_row;
    assign o_dbg_state   = r_state;
endmodule
